// File: rtl/sdram_arbiter_if.sv
// Shared constants and the reader/writer/controller bundle for sdram_arbiter.
package sdram_arbiter_pkg;
  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CMD_W  = 2;

  // Controller command encodings, kept identical to sdram.vh
  localparam logic [CMD_W-1:0] CMD_IDLE  = 2'b00;
  localparam logic [CMD_W-1:0] CMD_READ  = 2'b01;
  localparam logic [CMD_W-1:0] CMD_WRITE = 2'b10;
endpackage

// Reader, writer and controller signals seen by the arbiter.
interface sdram_arbiter_if;
  import sdram_arbiter_pkg::*;

  // reader side
  logic              i_Rd_Req;
  logic [ADDR_W-1:0] i_Rd_Addr;
  logic              o_Rd_Grant;
  logic              o_Rd_Data_Valid;
  logic [DATA_W-1:0] o_Rd_Data;
  // writer side
  logic              i_Wr_Req;
  logic [ADDR_W-1:0] i_Wr_Addr;
  logic [DATA_W-1:0] i_Wr_Data;
  logic              o_Wr_Pop;
  logic              o_Wr_Grant;
  // controller side
  logic [CMD_W-1:0]  o_Command;
  logic [ADDR_W-1:0] o_Data_Address;
  logic [DATA_W-1:0] o_Data_Write;
  logic [DATA_W-1:0] i_Data_Read;
  logic              i_Data_Read_Valid;
  logic              i_Data_Write_Done;
  logic              o_Busy;

  // arbiter view
  modport master (
    input  i_Rd_Req, i_Rd_Addr, i_Wr_Req, i_Wr_Addr, i_Wr_Data,
           i_Data_Read, i_Data_Read_Valid, i_Data_Write_Done,
    output o_Rd_Grant, o_Rd_Data_Valid, o_Rd_Data, o_Wr_Pop, o_Wr_Grant,
           o_Command, o_Data_Address, o_Data_Write, o_Busy
  );

  // environment view (clients plus controller)
  modport slave (
    output i_Rd_Req, i_Rd_Addr, i_Wr_Req, i_Wr_Addr, i_Wr_Data,
           i_Data_Read, i_Data_Read_Valid, i_Data_Write_Done,
    input  o_Rd_Grant, o_Rd_Data_Valid, o_Rd_Data, o_Wr_Pop, o_Wr_Grant,
           o_Command, o_Data_Address, o_Data_Write, o_Busy
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-client burst arbiter in front of an SDRAM controller: one reader, one
// writer, fixed-length bursts, read priority with a bounded read streak.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned BURST_LENGTH = 8,
  parameter int unsigned FRAME_WORDS  = 96000,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  sdram_arbiter_if.master  bus
);

  localparam int unsigned CNT_W    = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  localparam int unsigned STREAK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(BURST_LENGTH - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0]   ADDR_LAST  = ADDR_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, GAP} state_t;

  state_t              state_q, state_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                rd_grant_q, rd_grant_d;
  logic                wr_grant_q, wr_grant_d;
  logic                busy_q, busy_d;
  logic                arm_q;
  logic                pop_c;
  logic                pick_write_c;

  // Word address after one transfer; only the frame's last word wraps.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_LAST) ? '0 : a + ADDR_W'(1);
  endfunction

  // Write wins when no read is pending or the reader has used up its streak.
  assign pick_write_c = bus.i_Wr_Req && (!bus.i_Rd_Req || (streak_q == STREAK_MAX));

  // State and datapath registers; reset drops any burst in flight.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= IDLE;
      cmd_q      <= CMD_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      streak_q   <= '0;
      rd_grant_q <= 1'b0;
      wr_grant_q <= 1'b0;
      busy_q     <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      rd_grant_q <= rd_grant_d;
      wr_grant_q <= wr_grant_d;
      busy_q     <= busy_d;
      arm_q      <= 1'b1;
    end
  end

  // Next-state, arbitration and burst bookkeeping.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    rd_grant_d = 1'b0;
    wr_grant_d = 1'b0;
    pop_c      = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_d = CMD_IDLE;
        // arm_q holds off grants until one full edge after reset release
        if (arm_q && (bus.i_Rd_Req || bus.i_Wr_Req)) begin
          cnt_d = CNT_LOAD;
          if (pick_write_c) begin
            state_d    = WRITE;
            cmd_d      = CMD_WRITE;
            addr_d     = bus.i_Wr_Addr;
            wdata_d    = bus.i_Wr_Data;
            pop_c      = 1'b1;
            wr_grant_d = 1'b1;
            streak_d   = '0;
          end else begin
            state_d    = READ;
            cmd_d      = CMD_READ;
            addr_d     = bus.i_Rd_Addr;
            rd_grant_d = 1'b1;
            if (!bus.i_Wr_Req) begin
              streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
              streak_d = streak_q + STREAK_W'(1);
            end
          end
        end
      end

      READ: begin
        if (bus.i_Data_Read_Valid) begin
          addr_d = next_addr(addr_q);
          if (cnt_q == '0) begin
            state_d = GAP;
            cmd_d   = CMD_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      WRITE: begin
        if (bus.i_Data_Write_Done) begin
          addr_d = next_addr(addr_q);
          if (cnt_q == '0) begin
            state_d = GAP;
            cmd_d   = CMD_IDLE;
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
            wdata_d = bus.i_Wr_Data;
            pop_c   = 1'b1;
          end
        end
      end

      GAP: begin
        state_d = IDLE;
        cmd_d   = CMD_IDLE;
      end

      default: begin
        state_d = IDLE;
        cmd_d   = CMD_IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Registered outputs plus the pass-through read path and pop strobe.
  assign bus.o_Command       = cmd_q;
  assign bus.o_Data_Address  = addr_q;
  assign bus.o_Data_Write    = wdata_q;
  assign bus.o_Rd_Grant      = rd_grant_q;
  assign bus.o_Wr_Grant      = wr_grant_q;
  assign bus.o_Busy          = busy_q;
  assign bus.o_Wr_Pop        = pop_c;
  assign bus.o_Rd_Data_Valid = (state_q == READ) && bus.i_Data_Read_Valid;
  assign bus.o_Rd_Data       = bus.i_Data_Read;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: read/write bursts, wrap, stray strobes,
// contention fairness and mid-burst reset.
module tb_sdram_arbiter;

  logic i_Clk = 1'b0;
  logic i_Rst_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_Clk = ~i_Clk;

  sdram_arbiter_if bus ();

  sdram_arbiter #(
    .BURST_LENGTH(8),
    .FRAME_WORDS (96000),
    .STARVE_LIMIT(4)
  ) dut (
    .i_Clk  (i_Clk),
    .i_Rst_n(i_Rst_n),
    .bus    (bus.master)
  );

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  function automatic logic [31:0] wr_word(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  function automatic logic [31:0] wr_addr_exp(input int k);
    int a;
    a = 95996 + k;
    if (a >= 96000) a = a - 96000;
    return 32'(a);
  endfunction

  initial begin
    int  pops;
    int  ng;
    int  idle_run;
    logic exp_w [6];

    exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    bus.i_Rd_Req          = 1'b0;
    bus.i_Rd_Addr         = '0;
    bus.i_Wr_Req          = 1'b0;
    bus.i_Wr_Addr         = '0;
    bus.i_Wr_Data         = '0;
    bus.i_Data_Read       = '0;
    bus.i_Data_Read_Valid = 1'b0;
    bus.i_Data_Write_Done = 1'b0;
    i_Rst_n               = 1'b0;

    // reset state, before any clock edge
    #3;
    check("rst_cmd",   32'(bus.o_Command), 32'd0);
    check("rst_addr",  32'(bus.o_Data_Address), 32'd0);
    check("rst_wdata", bus.o_Data_Write, 32'd0);
    check("rst_busy",  32'(bus.o_Busy), 32'd0);
    check("rst_rgnt",  32'(bus.o_Rd_Grant), 32'd0);
    check("rst_wgnt",  32'(bus.o_Wr_Grant), 32'd0);
    tick();
    tick();

    // read burst at 100, request already high at release
    bus.i_Rd_Req  = 1'b1;
    bus.i_Rd_Addr = 22'd100;
    i_Rst_n       = 1'b1;
    tick();
    check("rel1_rgnt", 32'(bus.o_Rd_Grant), 32'd0);
    check("rel1_busy", 32'(bus.o_Busy), 32'd0);
    tick();
    check("rd_grant", 32'(bus.o_Rd_Grant), 32'd1);
    check("rd_cmd",   32'(bus.o_Command), 32'd1);
    check("rd_addr0", 32'(bus.o_Data_Address), 32'd100);
    check("rd_busy",  32'(bus.o_Busy), 32'd1);
    bus.i_Rd_Req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.i_Data_Read_Valid = 1'b1;
      bus.i_Data_Read       = 32'hA000_0000 + 32'(k);
      #1;
      check($sformatf("rd_valid%0d", k), 32'(bus.o_Rd_Data_Valid), 32'd1);
      check($sformatf("rd_data%0d", k),  bus.o_Rd_Data, 32'hA000_0000 + 32'(k));
      check($sformatf("rd_addr%0d", k),  32'(bus.o_Data_Address), 32'd100 + 32'(k));
      tick();
      if (k == 0) check("rd_grant_pulse", 32'(bus.o_Rd_Grant), 32'd0);
    end
    bus.i_Data_Read_Valid = 1'b0;
    check("rd_gap_cmd",  32'(bus.o_Command), 32'd0);
    check("rd_gap_busy", 32'(bus.o_Busy), 32'd1);
    tick();
    check("rd_idle_busy", 32'(bus.o_Busy), 32'd0);

    // write burst crossing the frame wrap
    bus.i_Wr_Req  = 1'b1;
    bus.i_Wr_Addr = 22'd95996;
    bus.i_Wr_Data = wr_word(0);
    #1;
    check("wr_pop_grant", 32'(bus.o_Wr_Pop), 32'd1);
    pops = bus.o_Wr_Pop ? 1 : 0;
    tick();
    check("wr_grant", 32'(bus.o_Wr_Grant), 32'd1);
    check("wr_cmd",   32'(bus.o_Command), 32'd2);
    check("wr_addr0", 32'(bus.o_Data_Address), 32'd95996);
    check("wr_data0", bus.o_Data_Write, wr_word(0));
    bus.i_Wr_Req = 1'b0;
    // stray read strobe during WRITE
    bus.i_Data_Read_Valid = 1'b1;
    #1;
    check("stray_rvalid", 32'(bus.o_Rd_Data_Valid), 32'd0);
    check("stray_rpop",   32'(bus.o_Wr_Pop), 32'd0);
    tick();
    bus.i_Data_Read_Valid = 1'b0;
    check("stray_raddr", 32'(bus.o_Data_Address), 32'd95996);
    for (int k = 0; k < 8; k++) begin
      bus.i_Data_Write_Done = 1'b1;
      bus.i_Wr_Data         = wr_word(k + 1);
      #1;
      check($sformatf("wr_pop%0d", k),  32'(bus.o_Wr_Pop), (k < 7) ? 32'd1 : 32'd0);
      check($sformatf("wr_addr%0d", k), 32'(bus.o_Data_Address), wr_addr_exp(k));
      if (bus.o_Wr_Pop) pops++;
      tick();
      if (k < 7) check($sformatf("wr_data%0d", k + 1), bus.o_Data_Write, wr_word(k + 1));
    end
    bus.i_Data_Write_Done = 1'b0;
    check("wr_pops",     32'(pops), 32'd8);
    check("wr_gap_cmd",  32'(bus.o_Command), 32'd0);
    check("wr_gap_busy", 32'(bus.o_Busy), 32'd1);
    tick();
    check("wr_idle_busy", 32'(bus.o_Busy), 32'd0);
    check("wr_end_addr",  32'(bus.o_Data_Address), 32'd4);

    // stray write-done in IDLE
    bus.i_Data_Write_Done = 1'b1;
    #1;
    check("stray_dpop", 32'(bus.o_Wr_Pop), 32'd0);
    tick();
    bus.i_Data_Write_Done = 1'b0;
    check("stray_daddr", 32'(bus.o_Data_Address), 32'd4);
    check("stray_dbusy", 32'(bus.o_Busy), 32'd0);

    // contention: both requests held, strobes always present
    bus.i_Rd_Req          = 1'b1;
    bus.i_Rd_Addr         = 22'd300;
    bus.i_Wr_Req          = 1'b1;
    bus.i_Wr_Addr         = 22'd400;
    bus.i_Data_Read_Valid = 1'b1;
    bus.i_Data_Write_Done = 1'b1;
    ng       = 0;
    idle_run = 0;
    for (int cyc = 0; cyc < 300 && ng < 6; cyc++) begin
      tick();
      if (bus.o_Rd_Grant || bus.o_Wr_Grant) begin
        check($sformatf("cont_one%0d", ng),  32'(bus.o_Rd_Grant && bus.o_Wr_Grant), 32'd0);
        check($sformatf("cont_kind%0d", ng), 32'(bus.o_Wr_Grant), 32'(exp_w[ng]));
        if (ng > 0) check($sformatf("cont_gap%0d", ng), 32'(idle_run >= 2), 32'd1);
        ng++;
        idle_run = 0;
      end else if (bus.o_Command == 2'd0) begin
        idle_run++;
      end
    end
    check("cont_grants", 32'(ng), 32'd6);
    bus.i_Rd_Req = 1'b0;
    bus.i_Wr_Req = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      tick();
      if (!bus.o_Busy) break;
    end
    check("cont_drain", 32'(bus.o_Busy), 32'd0);
    bus.i_Data_Read_Valid = 1'b0;
    bus.i_Data_Write_Done = 1'b0;
    tick();

    // reset in the middle of a write burst
    bus.i_Wr_Req  = 1'b1;
    bus.i_Wr_Addr = 22'd50;
    bus.i_Wr_Data = 32'h1234_5678;
    tick();
    check("mr_grant", 32'(bus.o_Wr_Grant), 32'd1);
    bus.i_Wr_Req          = 1'b0;
    bus.i_Data_Write_Done = 1'b1;
    tick();
    tick();
    tick();
    bus.i_Data_Write_Done = 1'b0;
    check("mr_addr3", 32'(bus.o_Data_Address), 32'd53);
    #2;
    i_Rst_n = 1'b0;
    #1;
    check("mr_cmd",   32'(bus.o_Command), 32'd0);
    check("mr_addr",  32'(bus.o_Data_Address), 32'd0);
    check("mr_busy",  32'(bus.o_Busy), 32'd0);
    check("mr_wdata", bus.o_Data_Write, 32'd0);
    tick();
    tick();
    bus.i_Wr_Req  = 1'b1;
    bus.i_Wr_Addr = 22'd200;
    i_Rst_n       = 1'b1;
    tick();
    check("mr_rel1_wgnt", 32'(bus.o_Wr_Grant), 32'd0);
    check("mr_rel1_busy", 32'(bus.o_Busy), 32'd0);
    tick();
    check("mr_rel2_wgnt", 32'(bus.o_Wr_Grant), 32'd1);
    check("mr_rel2_addr", 32'(bus.o_Data_Address), 32'd200);
    bus.i_Wr_Req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- BURST_LENGTH, 8, words per granted burst.
- FRAME_WORDS, 96000, address wrap point (480*200).
- STARVE_LIMIT, 4, consecutive read bursts allowed while a write is pending.
REQ-002 Command encodings SHALL be CMD_IDLE, CMD_READ and CMD_WRITE from sdram.vh.
REQ-003 The ports SHALL be (name, direction, width, meaning):
- i_Clk, in, 1, sole clock.
- i_Rst_n, in, 1, reset, asynchronous active-low.
- i_Rd_Req, in, 1, reader requests one burst.
- i_Rd_Addr, in, 22, reader burst base address.
- o_Rd_Grant, out, 1, one-cycle pulse at read-burst start.
- o_Rd_Data_Valid, out, 1, read word present.
- o_Rd_Data, out, 32, read word.
- i_Wr_Req, in, 1, writer requests one burst.
- i_Wr_Addr, in, 22, writer burst base address.
- i_Wr_Data, in, 32, show-ahead write word.
- o_Wr_Pop, out, 1, i_Wr_Data consumed this cycle.
- o_Wr_Grant, out, 1, one-cycle pulse at write-burst start.
- o_Command, out, 2, controller command.
- o_Data_Address, out, 22, controller word address.
- o_Data_Write, out, 32, controller write word.
- i_Data_Read, in, 32, controller read word.
- i_Data_Read_Valid, in, 1, controller read word valid.
- i_Data_Write_Done, in, 1, controller accepted o_Data_Write.
- o_Busy, out, 1, burst in progress.

Function
REQ-004 States SHALL be IDLE, READ, WRITE and GAP; GAP SHALL drive CMD_IDLE for exactly one cycle, then go to IDLE.
REQ-005 In IDLE with any request, the next edge SHALL enter READ or WRITE, set o_Command accordingly, load o_Data_Address from the granted base address, pulse the matching grant, and load the countdown with BURST_LENGTH-1.
REQ-006 Arbitration SHALL be as follows:
- Read wins by default.
- Write wins when i_Rd_Req is low.
- Write wins when read_streak==STARVE_LIMIT and i_Wr_Req is high.
REQ-007 read_streak SHALL increment on each read grant while i_Wr_Req is high, saturate at STARVE_LIMIT, and clear on a write grant or on any read grant made while i_Wr_Req is low.
REQ-008 In READ, o_Rd_Data_Valid SHALL be combinational (state==READ && i_Data_Read_Valid), and o_Rd_Data SHALL be i_Data_Read passed through.
REQ-009 In READ, i_Data_Read_Valid outside READ SHALL be ignored.
REQ-010 In WRITE, i_Data_Write_Done outside WRITE SHALL be ignored.
REQ-011 Each valid read word or write-done SHALL advance o_Data_Address by 1, wrapping FRAME_WORDS-1 to 0.
REQ-012 Each valid read word or write-done SHALL decrement the countdown; at countdown 0 the state SHALL go to GAP with o_Command=CMD_IDLE.
REQ-013 Write data SHALL be handled as follows:
- o_Data_Write SHALL capture i_Wr_Data on the IDLE-to-WRITE edge.
- o_Data_Write SHALL capture i_Wr_Data on each non-final i_Data_Write_Done.
- o_Wr_Pop SHALL be combinational and high exactly in the cycles of those captures.
- There SHALL be exactly BURST_LENGTH pops per write burst.
REQ-014 A base address >= FRAME_WORDS SHALL be loaded unchanged; wrap applies only on increment past FRAME_WORDS-1.
REQ-015 Request lines SHALL be sampled only in IDLE; deassertion mid-burst SHALL NOT abort the burst.
REQ-016 Both requests asserted in IDLE SHALL resolve per REQ-006 in the same cycle, producing one grant only.
REQ-017 o_Busy SHALL be high in READ, WRITE and GAP.
REQ-018 Back-to-back bursts SHALL be separated by at least 2 CMD_IDLE cycles (GAP plus IDLE).

Reset
REQ-019 On i_Rst_n low, independent of i_Clk and including mid-burst, the block SHALL immediately:
- Enter state IDLE.
- Drive o_Command=CMD_IDLE.
- Clear o_Data_Address, o_Data_Write and the countdown to 0.
- Clear read_streak to 0.
- Clear o_Rd_Grant, o_Wr_Grant and o_Busy to 0.
REQ-020 After release, the first request SHALL be granted no earlier than the second rising edge.
REQ-021 A burst interrupted by reset SHALL NOT resume.

Verification
REQ-022 Read burst: i_Rd_Req=1, i_Rd_Addr=100, 8 read-valid pulses
-> o_Rd_Grant pulses once
-> addresses 100..107
-> 8 o_Rd_Data_Valid
-> GAP cycle then IDLE.
REQ-023 Write burst: i_Wr_Req=1, i_Wr_Addr=95996, 8 write-done pulses
-> 8 o_Wr_Pop
-> addresses 95996..95999, 0..3
-> o_Data_Write sequence equals the popped words.
REQ-024 Contention: both requests held high continuously
-> 4 read grants, 1 write grant, then read_streak cleared and reads resume.
REQ-025 Mid-burst reset: assert i_Rst_n=0 after 3 write-done pulses
-> o_Command=CMD_IDLE, o_Data_Address=0 and o_Busy=0 before the next edge
-> no grant until the second edge after release.
REQ-026 Stray strobes: i_Data_Read_Valid in WRITE and i_Data_Write_Done in IDLE
-> no address change, no o_Rd_Data_Valid, no o_Wr_Pop.
